// File: rtl/itcm_ctrl_pkg.sv
// Shared ITCM defines and types: PC/instruction widths, default depth, response entry layout.
// Optional build macro ITCM_MISALIGN_CHK_EN is consumed by itcm_ctrl.sv.
`ifndef ITCM_CTRL_DEFINES
`define ITCM_CTRL_DEFINES
`define PC_SIZE          32
`define INSTR_SIZE       32
`define ITCM_AW_DEFAULT  10
`endif

package itcm_ctrl_pkg;

  localparam int PC_W    = `PC_SIZE;
  localparam int INSTR_W = `INSTR_SIZE;

  typedef struct packed {
    logic               err;
    logic [INSTR_W-1:0] instr;
  } itcm_rsp_t;

  localparam int RSP_W = $bits(itcm_rsp_t);

endpackage

// File: rtl/itcm_ctrl_if.sv
// IFU fetch request/response channel between the instruction fetch unit and the ITCM controller.
interface itcm_ctrl_if;
  import itcm_ctrl_pkg::*;

  logic               ifu_req_valid;
  logic               ifu_req_ready;
  logic [PC_W-1:0]    ifu_req_pc;
  logic               ifu_rsp_valid;
  logic               ifu_rsp_ready;
  logic [INSTR_W-1:0] ifu_rsp_instr;
  logic               ifu_rsp_err;

  modport master (
    output ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err
  );

  modport slave (
    input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err
  );
endinterface

// File: rtl/itcm_rsp_fifo.sv
// Two-entry in-order response FIFO; entries clear on reset so the head reads zero when idle.
module itcm_rsp_fifo
  import itcm_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  itcm_rsp_t push_data,
  input  logic      pop,
  output itcm_rsp_t head,
  output logic [1:0] count
);

  itcm_rsp_t  entry_q [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) entry_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        entry_q[wr_ptr_q] <= push_data;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = entry_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/itcm_ctrl.sv
// ITCM controller: word-addressed instruction memory with a write port and 1-cycle fetch via a 2-deep response FIFO.
// Build option ITCM_MISALIGN_CHK_EN: misaligned fetch PCs return err=1, instr=0.
module itcm_ctrl
  import itcm_ctrl_pkg::*;
#(
  parameter int ITCM_AW = `ITCM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  itcm_ctrl_if.slave         ifu,
  input  logic               itcm_wr_en,
  input  logic [ITCM_AW-1:0] itcm_wr_addr,
  input  logic [INSTR_W-1:0] itcm_wr_data
);

  localparam int DEPTH = 1 << ITCM_AW;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [ITCM_AW-1:0] rd_idx;
  logic [INSTR_W-1:0] rd_word;
  logic [1:0]         fifo_count;
  logic               accept;
  logic               pop;
  itcm_rsp_t          push_rsp;
  itcm_rsp_t          head_rsp;
  logic               unused_pc_bits;

  always_ff @(posedge clk) begin
    if (itcm_wr_en) mem[itcm_wr_addr] <= itcm_wr_data;
  end

  // Upper PC bits fall off the index so fetches wrap modulo the array depth.
  assign rd_idx  = ifu.ifu_req_pc[ITCM_AW+1:2];
  assign rd_word = mem[rd_idx];

  assign ifu.ifu_req_ready = (fifo_count != 2'd2) && !itcm_wr_en;
  assign accept            = ifu.ifu_req_valid && ifu.ifu_req_ready;
  assign pop               = ifu.ifu_rsp_valid && ifu.ifu_rsp_ready;

`ifdef ITCM_MISALIGN_CHK_EN
  logic misaligned;
  assign misaligned     = |ifu.ifu_req_pc[1:0];
  assign push_rsp.err   = misaligned;
  assign push_rsp.instr = misaligned ? '0 : rd_word;
  assign unused_pc_bits = ^ifu.ifu_req_pc[PC_W-1:ITCM_AW+2];
`else
  assign push_rsp.err   = 1'b0;
  assign push_rsp.instr = rd_word;
  assign unused_pc_bits = ^{ifu.ifu_req_pc[PC_W-1:ITCM_AW+2], ifu.ifu_req_pc[1:0]};
`endif

  itcm_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_rsp),
    .pop       (pop),
    .head      (head_rsp),
    .count     (fifo_count)
  );

  assign ifu.ifu_rsp_valid = (fifo_count != 2'd0);
  assign ifu.ifu_rsp_instr = head_rsp.instr;
`ifdef ITCM_MISALIGN_CHK_EN
  assign ifu.ifu_rsp_err   = head_rsp.err;
`else
  assign ifu.ifu_rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_itcm_ctrl.sv
// Directed bench for itcm_ctrl: preload, fetch latency, backpressure, write priority, wrap/misalign, reset flush.
module tb_itcm_ctrl;
  import itcm_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        itcm_wr_en = 1'b0;
  logic [9:0]  itcm_wr_addr = '0;
  logic [31:0] itcm_wr_data = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  itcm_ctrl_if ifu_if ();

  itcm_ctrl #(.ITCM_AW(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifu          (ifu_if),
    .itcm_wr_en   (itcm_wr_en),
    .itcm_wr_addr (itcm_wr_addr),
    .itcm_wr_data (itcm_wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs, then let combinational outputs settle.
  task automatic step(input logic vld, input logic [31:0] pc, input logic rrdy);
    @(negedge clk);
    ifu_if.ifu_req_valid = vld;
    ifu_if.ifu_req_pc    = pc;
    ifu_if.ifu_rsp_ready = rrdy;
    #1;
  endtask

  task automatic write_word(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    itcm_wr_en   = 1'b1;
    itcm_wr_addr = a;
    itcm_wr_data = d;
    @(negedge clk);
    itcm_wr_en   = 1'b0;
  endtask

  initial begin
    ifu_if.ifu_req_valid = 1'b0;
    ifu_if.ifu_req_pc    = '0;
    ifu_if.ifu_rsp_ready = 1'b0;
    #12;
    chk("rst_rsp_valid", 32'(ifu_if.ifu_rsp_valid), 32'd0);
    chk("rst_rsp_instr", ifu_if.ifu_rsp_instr, 32'd0);
    chk("rst_rsp_err",   32'(ifu_if.ifu_rsp_err), 32'd0);
    chk("rst_req_ready", 32'(ifu_if.ifu_req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    write_word(10'd0, 32'h0000_1137);
    write_word(10'd1, 32'h0000_0013);
    write_word(10'd2, 32'h1234_5678);

    // Basic fetch: one response per cycle, latency 1.
    step(1'b1, 32'h0, 1'b1);
    chk("f0_ready",     32'(ifu_if.ifu_req_ready), 32'd1);
    chk("f0_rsp_idle",  32'(ifu_if.ifu_rsp_valid), 32'd0);
    step(1'b1, 32'h4, 1'b1);
    chk("f0_rsp_valid", 32'(ifu_if.ifu_rsp_valid), 32'd1);
    chk("f0_rsp_instr", ifu_if.ifu_rsp_instr, 32'h0000_1137);
    step(1'b0, 32'h0, 1'b1);
    chk("f1_rsp_valid", 32'(ifu_if.ifu_rsp_valid), 32'd1);
    chk("f1_rsp_instr", ifu_if.ifu_rsp_instr, 32'h0000_0013);
    step(1'b0, 32'h0, 1'b1);
    chk("f_drained",    32'(ifu_if.ifu_rsp_valid), 32'd0);

    // Backpressure: two accepted, third stalls until a slot frees.
    step(1'b1, 32'h0, 1'b0);
    chk("bp_a_ready",   32'(ifu_if.ifu_req_ready), 32'd1);
    step(1'b1, 32'h4, 1'b0);
    chk("bp_b_ready",   32'(ifu_if.ifu_req_ready), 32'd1);
    chk("bp_head_a",    ifu_if.ifu_rsp_instr, 32'h0000_1137);
    step(1'b1, 32'h8, 1'b0);
    chk("bp_full_rdy",  32'(ifu_if.ifu_req_ready), 32'd0);
    chk("bp_hold_a",    ifu_if.ifu_rsp_instr, 32'h0000_1137);
    step(1'b1, 32'h8, 1'b0);
    chk("bp_full_rdy2", 32'(ifu_if.ifu_req_ready), 32'd0);
    chk("bp_hold_a2",   ifu_if.ifu_rsp_instr, 32'h0000_1137);
    step(1'b1, 32'h8, 1'b1);
    chk("bp_no_credit", 32'(ifu_if.ifu_req_ready), 32'd0);
    step(1'b1, 32'h8, 1'b1);
    chk("bp_c_ready",   32'(ifu_if.ifu_req_ready), 32'd1);
    chk("bp_head_b",    ifu_if.ifu_rsp_instr, 32'h0000_0013);
    step(1'b0, 32'h0, 1'b1);
    chk("bp_c_valid",   32'(ifu_if.ifu_rsp_valid), 32'd1);
    chk("bp_head_c",    ifu_if.ifu_rsp_instr, 32'h1234_5678);
    step(1'b0, 32'h0, 1'b1);
    chk("bp_drained",   32'(ifu_if.ifu_rsp_valid), 32'd0);

    // Write has priority; the following cycle's read sees the new word.
    @(negedge clk);
    itcm_wr_en   = 1'b1;
    itcm_wr_addr = 10'd5;
    itcm_wr_data = 32'hDEAD_BEEF;
    ifu_if.ifu_req_valid = 1'b1;
    ifu_if.ifu_req_pc    = 32'h14;
    ifu_if.ifu_rsp_ready = 1'b1;
    #1;
    chk("wr_blocks_rdy", 32'(ifu_if.ifu_req_ready), 32'd0);
    @(negedge clk);
    itcm_wr_en = 1'b0;
    #1;
    chk("wr_no_accept",  32'(ifu_if.ifu_rsp_valid), 32'd0);
    chk("wr_ready_back", 32'(ifu_if.ifu_req_ready), 32'd1);
    step(1'b0, 32'h0, 1'b1);
    chk("wr_rd_valid",   32'(ifu_if.ifu_rsp_valid), 32'd1);
    chk("wr_rd_instr",   ifu_if.ifu_rsp_instr, 32'hDEAD_BEEF);

    // Address wrap and misaligned PC.
    step(1'b1, 32'h1001, 1'b1);
    step(1'b1, 32'h1004, 1'b1);
`ifdef ITCM_MISALIGN_CHK_EN
    chk("mis_err",   32'(ifu_if.ifu_rsp_err), 32'd1);
    chk("mis_instr", ifu_if.ifu_rsp_instr, 32'd0);
`else
    chk("mis_err",   32'(ifu_if.ifu_rsp_err), 32'd0);
    chk("mis_instr", ifu_if.ifu_rsp_instr, 32'h0000_1137);
`endif
    step(1'b0, 32'h0, 1'b1);
    chk("wrap_err",   32'(ifu_if.ifu_rsp_err), 32'd0);
    chk("wrap_instr", ifu_if.ifu_rsp_instr, 32'h0000_0013);
    step(1'b0, 32'h0, 1'b1);

    // Reset with two buffered responses.
    step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h4, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("pre_rst_full", 32'(ifu_if.ifu_req_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(ifu_if.ifu_rsp_valid), 32'd0);
    chk("rst_mid_instr", ifu_if.ifu_rsp_instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ifu_if.ifu_rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(ifu_if.ifu_req_ready), 32'd1);
    chk("post_rst_valid", 32'(ifu_if.ifu_rsp_valid), 32'd0);
    step(1'b0, 32'h0, 1'b1);
    chk("no_stale_rsp",   32'(ifu_if.ifu_rsp_valid), 32'd0);
    step(1'b1, 32'h4, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("mem_kept_valid", 32'(ifu_if.ifu_rsp_valid), 32'd1);
    chk("mem_kept_instr", ifu_if.ifu_rsp_instr, 32'h0000_0013);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
